demux1x4_stream: RTL

DEMUX1X4_STREAM -- requirements
Module: demux1x4_stream

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 33 +++
 rtl/demux1x4_stream.sv | 66 ++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1x4 stream demultiplexer: slot state encoding,
// channel count and per-channel transfer counter width.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry channel register: load wins over take, so a same-cycle take and
// load stays FULL with the new payload and leaves no bubble.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_e state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
        end else if (load) begin
            state <= FULL;
            data  <= load_data;
        end else if (take) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux1x4_stream.sv
// Valid/ready 1-to-4 stream demultiplexer with an independent one-entry slot
// per channel. Define DEMUX_CNT_EN to add per-channel transfer counters (cnt).
module demux1x4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
`ifdef DEMUX_CNT_EN
    output logic                 busy,
    output logic [NCH*CNT_W-1:0] cnt
`else
    output logic                 busy
`endif
);

    logic [NCH-1:0] load;
    logic [NCH-1:0] take;

    // Only the addressed channel gates acceptance, so a stalled channel never
    // blocks traffic headed elsewhere.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign busy     = |out_valid;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign load[k] = in_valid && in_ready && (in_sel == 2'(k));
        assign take[k] = out_valid[k] && out_ready[k];

        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(in_data),
            .take     (take[k]),
            .data     (out_data[k*WIDTH +: WIDTH]),
            .valid    (out_valid[k])
        );
    end

`ifdef DEMUX_CNT_EN
    logic [NCH-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (take[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    assign cnt = cnt_q;
`endif

endmodule
